// File: rtl/gray_lbp_pkg.sv
// gray_lbp_pkg: shared state encoding, image geometry and border test for the gray/LBP host
package gray_lbp_pkg;
    typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DUMP, ST_DONE} state_t;
    localparam int LBP_IMG_W = 128;
    localparam int IMG_PIX   = LBP_IMG_W * LBP_IMG_W;
    localparam int LAST_ADDR = IMG_PIX - 1;
    // A pixel is on the border when it sits in the first/last row or column.
    function automatic logic is_border(input logic [31:0] addr, input int w);
        logic [31:0] row;
        logic [31:0] col;
        row = addr / w;
        col = addr % w;
        return row == 0 || row == 32'(w - 1) || col == 0 || col == 32'(w - 1);
    endfunction
endpackage

// File: rtl/gray_lbp_dpram.sv
// gray_lbp_dpram: DW x 2^AW memory, one synchronous write port and one asynchronous read port
module gray_lbp_dpram #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    // Contents are never reset; a reload always precedes use.
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/gray_lbp_host.sv
// gray_lbp_host: image store / LBP result capture / result dump host; GRAY_LBP_HOST_CHKSUM_EN adds checksum and overwrite detection
module gray_lbp_host
    import gray_lbp_pkg::*;
#(
    parameter int AW    = 14,
    parameter int DW    = 8,
    parameter int IMG_W = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          dump_valid,
    output logic [DW-1:0] dump_data,
    input  logic          dump_ready,
    output logic          dump_last,
    output logic          done,
`ifdef GRAY_LBP_HOST_CHKSUM_EN
    output logic [15:0]   checksum,
`endif
    output logic          prot_err
);
    localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_W - 1);

    state_t        state, state_nx;
    logic [AW-1:0] ld_ptr, dump_ptr;
    logic [DW-1:0] img_rd, res_rd;
    logic          img_we, res_we, bad, dup;

    gray_lbp_dpram #(.AW(AW), .DW(DW)) img_mem (
        .clk(clk), .we(img_we), .waddr(ld_ptr), .wdata(load_data),
        .raddr(gray_addr), .rdata(img_rd)
    );

    gray_lbp_dpram #(.AW(AW), .DW(DW)) res_mem (
        .clk(clk), .we(res_we), .waddr(lbp_addr), .wdata(lbp_data),
        .raddr(dump_ptr), .rdata(res_rd)
    );

    assign load_ready = reset && state == ST_LOAD;
    assign gray_ready = state == ST_SERVE;
    assign gray_data  = (gray_ready && gray_req) ? img_rd : '0;
    assign dump_valid = state == ST_DUMP;
    assign dump_last  = dump_valid && dump_ptr == LAST;
    assign dump_data  = (dump_valid && !is_border(32'(dump_ptr), IMG_W)) ? res_rd : '0;
    assign done       = state == ST_DONE;

    // Next state, memory write enables and protocol-violation detection.
    always_comb begin
        state_nx = state;
        img_we   = 1'b0;
        res_we   = 1'b0;
        bad      = lbp_valid || gray_req;
        case (state)
            ST_LOAD: begin
                img_we = load_valid;
                if (load_valid && ld_ptr == LAST) state_nx = ST_SERVE;
            end
            ST_SERVE: begin
                res_we = lbp_valid;
                bad    = lbp_valid && (is_border(32'(lbp_addr), IMG_W) || dup);
                if (finish) state_nx = ST_DUMP;
            end
            ST_DUMP: if (dump_ready && dump_ptr == LAST) state_nx = ST_DONE;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= ST_LOAD;
        else        state <= state_nx;

    // Load/dump pointers and the sticky protocol-error flag.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ld_ptr   <= '0;
            dump_ptr <= '0;
            prot_err <= 1'b0;
        end else begin
            if (img_we) ld_ptr <= ld_ptr + 1'b1;
            if (dump_valid && dump_ready) dump_ptr <= dump_ptr + 1'b1;
            if (bad) prot_err <= 1'b1;
        end

`ifdef GRAY_LBP_HOST_CHKSUM_EN
    logic [2**AW-1:0] written;
    assign dup = written[lbp_addr];

    // Written bitmap, flash-cleared while loading so SERVE starts empty.
    always_ff @(posedge clk or negedge reset)
        if (!reset)                 written <= '0;
        else if (state == ST_LOAD)  written <= '0;
        else if (res_we)            written[lbp_addr] <= 1'b1;

    // Running sum of accepted dump bytes; naturally frozen once in DONE.
    always_ff @(posedge clk or negedge reset)
        if (!reset)                        checksum <= '0;
        else if (dump_valid && dump_ready) checksum <= checksum + 16'(dump_data);
`else
    assign dup = 1'b0;
`endif
endmodule

// File: tb/tb_gray_lbp_host.sv
// tb_gray_lbp_host: randomized scoreboard bench for gray_lbp_host (optionally with GRAY_LBP_HOST_CHKSUM_EN)
module tb_gray_lbp_host;
    localparam int N = 16384;
    localparam int W = 128;

    logic        clk = 0, reset = 0;
    logic        load_valid, load_ready, gray_ready, gray_req;
    logic [7:0]  load_data, gray_data, lbp_data, dump_data;
    logic [13:0] gray_addr, lbp_addr;
    logic        lbp_valid, finish, dump_valid, dump_ready, dump_last, done, prot_err;
`ifdef GRAY_LBP_HOST_CHKSUM_EN
    logic [15:0] checksum;
`endif

    gray_lbp_host dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .dump_last(dump_last), .done(done),
`ifdef GRAY_LBP_HOST_CHKSUM_EN
        .checksum(checksum),
`endif
        .prot_err(prot_err)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0, total = 0, hs_cnt = 0;
    logic [7:0] img_m [N];
    logic [7:0] res_m [N];
    logic [8:0] exp_q [$];
    logic [15:0] sum_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit border(input int a);
        int r = a / W;
        int c = a % W;
        return r == 0 || r == W - 1 || c == 0 || c == W - 1;
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin : mon
        logic [8:0] e;
        bit         st;
        logic [7:0] sd;
        logic       sl;
        st = 0;
        forever begin
            @(negedge clk);
            if (!reset) st = 0;
            else begin
                if (st && dump_valid) begin
                    chk("stall_data", dump_data, sd);
                    chk("stall_last", dump_last, sl);
                end
                st = dump_valid && !dump_ready;
                sd = dump_data;
                sl = dump_last;
                if (dump_valid && dump_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL dump_extra: handshake %0d with no expected byte", hs_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dump_data", dump_data, e[7:0]);
                        chk("dump_last", dump_last, e[8]);
                    end
                end
            end
        end
    end

    task automatic load_img(input bit gaps);
        int cnt = 0;
        while (cnt < N) begin
            @(negedge clk);
            if (cnt == 0 || cnt == N - 1) chk("load_ready_on", load_ready, 1);
            load_valid = gaps ? ($urandom_range(7) != 0) : 1'b1;
            load_data  = 8'($urandom);
            @(posedge clk);
            if (load_valid) begin
                img_m[cnt] = load_data;
                cnt++;
            end
        end
        @(negedge clk);
        load_valid = 0;
        chk("load_ready_drop", load_ready, 0);
        chk("gray_ready_up", gray_ready, 1);
    endtask

    // Builds the result model for addresses below lim and queues the expected dump bytes.
    task automatic prep_res(input int lim);
        sum_m = 0;
        for (int a = 0; a < lim; a++) begin
            res_m[a] = border(a) ? 8'h00 : 8'($urandom);
            if (a == 129) res_m[a] = 8'hA5;
            exp_q.push_back({a == N - 1, res_m[a]});
            sum_m += 16'(res_m[a]);
        end
    endtask

    task automatic write_res(input int lim, input bit with_border);
        int last_a = 0;
        for (int a = 0; a < lim; a++) if (!border(a)) last_a = a;
        if (with_border) begin
            @(negedge clk);
            chk("prot_err_clean", prot_err, 0);
            lbp_valid = 1; lbp_addr = 14'd127; lbp_data = 8'($urandom);
            @(negedge clk);
            lbp_valid = 0;
            chk("prot_err_border", prot_err, 1);
        end
        for (int a = 0; a < lim; a++) if (!border(a)) begin
            @(negedge clk);
            lbp_valid = 1; lbp_addr = 14'(a); lbp_data = res_m[a];
            finish = (a == last_a);
        end
        @(negedge clk);
        lbp_valid = 0; finish = 0;
    endtask

    task automatic wait_hs(input int target, input bit toggle);
        int k = 0;
        while (hs_cnt != target && k < 40000) begin
            @(posedge clk);
            k++;
            if (hs_cnt != target) begin
                #1 dump_ready = toggle ? ~dump_ready : 1'b1;
            end
        end
        if (hs_cnt != target) begin
            total++;
            $display("FAIL dump_timeout: handshakes %0d required %0d", hs_cnt, target);
        end
    endtask

    initial begin
        load_valid = 0; load_data = 0; gray_req = 0; gray_addr = 0;
        lbp_valid = 0; lbp_addr = 0; lbp_data = 0; finish = 0; dump_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_gray_ready", gray_ready, 0);
        chk("rst_gray_data", gray_data, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_last", dump_last, 0);
        chk("rst_done", done, 0);
        chk("rst_prot_err", prot_err, 0);
`ifdef GRAY_LBP_HOST_CHKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        reset = 1;

        load_img(1);
        @(negedge clk);
        gray_req = 1; gray_addr = 14'd129;
        #1 chk("gray_129", gray_data, img_m[129]);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            gray_addr = 14'($urandom);
            #1 chk("gray_rand", gray_data, img_m[gray_addr]);
        end
        @(negedge clk);
        gray_req = 0; gray_addr = 14'd5;
        #1 chk("gray_noreq", gray_data, 0);
        chk("prot_err_serve", prot_err, 0);

        prep_res(N);
        dump_ready = 1;
        write_res(N, 1);
        wait_hs(N, 1);
        @(negedge clk);
        chk("hs_count", hs_cnt, N);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_up", done, 1);
        chk("dump_valid_off", dump_valid, 0);
        chk("prot_err_sticky", prot_err, 1);
`ifdef GRAY_LBP_HOST_CHKSUM_EN
        chk("checksum", checksum, sum_m);
`endif
        repeat (5) @(negedge clk);
        chk("done_hold", done, 1);
        chk("prot_err_hold", prot_err, 1);
`ifdef GRAY_LBP_HOST_CHKSUM_EN
        chk("checksum_frozen", checksum, sum_m);
`endif

        reset = 0;
        @(negedge clk);
        reset = 1;
        hs_cnt = 0;
        load_img(0);
        prep_res(300);
        write_res(300, 0);
        wait_hs(300, 0);
        #1 reset = 0;
        #1;
        chk("mid_rst_dump_valid", dump_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_dump_last", dump_last, 0);
        chk("mid_rst_gray_ready", gray_ready, 0);
        chk("mid_rst_prot_err", prot_err, 0);
`ifdef GRAY_LBP_HOST_CHKSUM_EN
        chk("mid_rst_checksum", checksum, 0);
`endif
        chk("mid_rst_queue", exp_q.size(), 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("reload_ready", load_ready, 1);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
